mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
//  - Inputs: the ALU operand muxes (rs/rt values). Consumes them alongside the ALU.
//  - Outputs: hi/lo feed the writeback mux4 (MFHI/MFLO path).
//  - busy drives the PC flip-flop enable so the core holds while an op is in flight.
//  - One radix-2 step per cycle: shift-add for multiply, restoring for divide.
// PARAMETERS
//  Width  32  operand width; HI/LO are each Width bits; iteration count = Width
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      request; sampled on rising clk edge, accepted only when busy==0
//  op     in   3      mdu_pkg::mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  a      in   Width  rs operand (dividend / multiplicand / MTHI-MTLO source)
//  b      in   Width  rt operand (divisor / multiplier); ignored for MTHI/MTLO
//  busy   out  1      operation in flight; core must stall
//  done   out  1      1-cycle pulse; new HI/LO visible in this cycle
//  hi     out  Width  HI register
//  lo     out  Width  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; counter and work regs cleared. Applies mid-op:
//    the op in flight is abandoned and no HI/LO write occurs.
//  FSM: IDLE -> RUN -> FIX -> IDLE. busy = (state != IDLE); done is a registered output.
//  IDLE
//    - start & MTHI/MTLO: write hi (or lo) <= a at that edge; no busy; done stays 0.
//    - start & MULT*/DIV*: latch |a|, |b| (signed ops) or a, b (unsigned); latch result signs; cnt=0; -> RUN.
//    - start with an undefined op encoding: ignored.
//  RUN
//    - One iteration per cycle. On the edge where cnt==Width-1: -> FIX.
//  FIX
//    - Apply sign correction, write hi/lo, done<=1; -> IDLE.
//  Latency: accept at edge E0; busy high for exactly Width+1 cycles (E0+1 .. E0+Width+1).
//    - hi/lo update at edge E0+Width+1; done=1 in the following cycle, with busy=0.
//    - A new start may be accepted at the same edge at which done is first seen high.
//  start while busy (any op, incl. MTHI/MTLO): ignored, not queued. a/b may change after acceptance.
//  Multiply: 2*Width-bit product; {hi,lo} = product.
//    - Signed: product negated (two's complement, 2*Width bits) iff sign(a)^sign(b).
//  Divide: lo = quotient, hi = remainder.
//    - Signed: quotient negated iff sign(a)^sign(b); remainder takes sign(a).
//  Divide by zero: latency unchanged; lo = all-ones; hi = a (raw, unmodified).
//  Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (falls out of magnitude math).
//  hi/lo hold their values in all other cycles. MFHI/MFLO are combinational reads by the datapath.
// STRUCTURE
//  mdu_pkg: mdu_op_t enum (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5), mdu_state_t (IDLE, RUN, FIX).
//  mdu_sign_fix: combinational sub-module.
//    - Inputs: raw {hi,lo} magnitude, op, latched signs.
//    - Output: corrected {hi,lo}.
//  Counter: $clog2(Width) bits. Work regs:
//    - 2*Width accumulator/remainder-quotient pair.
//    - Width divisor/multiplicand.
// TESTING
//  1  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles; then done; hi=0xFFFFFFFE lo=0x00000001
//  2  MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF
//  3  DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0
//  4  MTHI a=0x1234 then MTLO a=0x5678 on consecutive edges -> hi=0x1234 lo=0x5678, busy/done never high
//  5  DIVU 10/3 in flight; pulse MTLO and a second DIVU mid-op -> both ignored; result lo=3 hi=1;
//     back-to-back start on the done cycle accepted
//  6  Assert rst at iteration 10 of MULTU -> busy=0 done=0 hi=lo=0 immediately; no later done pulse

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared types for the iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage : mdu_pkg

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// ============================================================================
// Module : mdu_sign_fix
// Brief  : Turns the unsigned magnitude result into the final HI/LO pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_mag,
  input  mdu_op_t            i_op,
  input  logic               i_neg_q,
  input  logic               i_neg_r,
  input  logic               i_dvz,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  always_comb begin
    w_prod_neg = -i_mag;
    w_q        = i_mag[WIDTH-1:0];
    w_r        = i_mag[2*WIDTH-1:WIDTH];
    o_hi       = i_mag[2*WIDTH-1:WIDTH];
    o_lo       = i_mag[WIDTH-1:0];
    if (i_op == DIV || i_op == DIVU) begin
      // Divide by zero: negating |a| by sign(a) restores the raw dividend in HI.
      o_lo = i_dvz ? '1 : (i_neg_q ? -w_q : w_q);
      o_hi = i_neg_r ? -w_r : w_r;
    end else if (i_neg_q) begin
      {o_hi, o_lo} = w_prod_neg;
    end
  end

endmodule : mdu_sign_fix

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module : mult_div_unit
// Brief  : Radix-2 iterative multiply/divide with architectural HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  mdu_state_t          r_state;
  mdu_state_t          w_next_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_opd;
  mdu_op_t             r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dvz;
  logic                r_done;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;

  logic                w_is_md;
  logic                w_signed;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [WIDTH:0]      w_madd;
  logic [2*WIDTH-1:0]  w_mul_next;
  logic                w_ge;
  logic [WIDTH-1:0]    w_diff;
  logic [2*WIDTH-1:0]  w_div_next;
  logic [WIDTH-1:0]    w_fix_hi;
  logic [WIDTH-1:0]    w_fix_lo;

  assign w_is_md  = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  assign w_signed = (op == MULT) || (op == DIV);
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Both ops keep |a| in the low half of r_acc and |b| in r_opd.
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

  assign w_ge       = r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opd};
  assign w_diff     = r_acc[2*WIDTH-2:WIDTH-1] - r_opd;
  assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {r_acc[2*WIDTH-2:0], 1'b0};

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .i_mag   (r_acc),
    .i_op    (r_op),
    .i_neg_q (r_neg_q),
    .i_neg_r (r_neg_r),
    .i_dvz   (r_dvz),
    .o_hi    (w_fix_hi),
    .o_lo    (w_fix_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start && w_is_md) w_next_state = RUN;
      RUN:     if (r_cnt == c_last)  w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_op    <= MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (start) begin
            if (op == MTHI) begin
              r_hi <= a;
            end else if (op == MTLO) begin
              r_lo <= a;
            end else if (w_is_md) begin
              r_op    <= op;
              r_cnt   <= '0;
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_opd   <= w_abs_b;
              r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r <= w_signed && a[WIDTH-1];
              r_dvz   <= (b == '0);
            end
          end
        end
        RUN: begin
          r_acc <= (r_op == DIV || r_op == DIVU) ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule : mult_div_unit

`default_nettype wire
